// File: rtl/ddr3_wr_pkg.sv
// Shared types and constants for the DDR3 write-side pixel packer.
// Holds the FSM state encoding and the pixel/word widths.
package ddr3_wr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ACTIVE,
      ST_SKIP
   } wr_state_t;

   localparam int PIX_W  = 16;
   localparam int WORD_W = 32;

   localparam logic [PIX_W-1:0] PAD_PIX = 16'h0000;

endpackage

// File: rtl/ddr3_wr_pixel_packer.sv
// Write-side front end of the DDR3 frame buffer: frame-start strobe, RGB565
// pair packing into 32-bit FIFO words, and per-frame geometry checking.
module ddr3_wr_pixel_packer
   import ddr3_wr_pkg::*;
#(
   parameter int IMG_W    = 1280,
   parameter int IMG_H    = 720,
   parameter int LOAD_LEN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              calib_done,
   input  logic              in_vsync,
   input  logic              in_de,
   input  logic [PIX_W-1:0]  in_data,
   output logic              wr_load,
   output logic              wrfifo_wren,
   output logic [WORD_W-1:0] wrfifo_din,
   output logic              frame_err,
   output logic [15:0]       frame_cnt
);

   localparam int PCW = $clog2(IMG_W + 1);
   localparam int LCW = $clog2(IMG_H + 1);
   localparam logic [PCW-1:0] PIX_MAX  = {PCW{1'b1}};
   localparam logic [LCW-1:0] LINE_MAX = {LCW{1'b1}};
   localparam logic [PCW-1:0] IMG_W_C  = PCW'(IMG_W);
   localparam logic [LCW-1:0] IMG_H_C  = LCW'(IMG_H);
   localparam logic [7:0]     LOAD_END = 8'(LOAD_LEN - 1);

   // Valid/ready note: the FIFO side has no ready; wrfifo_wren is a one-cycle
   // valid per word and the controller must always accept it.

   logic             s1_vs, s1_vs_d, s1_de, s1_de_d;
   logic [PIX_W-1:0] s1_data;
   logic             vs_rise, de_fall;

   wr_state_t        state_q, state_d;
   logic [7:0]       ld_cnt_q;
   logic [PCW-1:0]   pix_cnt_q;
   logic [LCW-1:0]   line_cnt_q, line_d;
   logic             phase_q;
   logic [PIX_W-1:0] low_q;
   logic             err_q, err_d, err_hold_q;
   logic [15:0]      frame_cnt_q;
   logic             wr_load_q, wren_q;
   logic [WORD_W-1:0] din_q;

   logic enter_load, take_pix, line_end, flush, line_err, frame_end;

   assign vs_rise = s1_vs & ~s1_vs_d;
   assign de_fall = ~s1_de & s1_de_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vs   <= 1'b0;
         s1_vs_d <= 1'b0;
         s1_de   <= 1'b0;
         s1_de_d <= 1'b0;
         s1_data <= '0;
      end else begin
         s1_vs   <= in_vsync;
         s1_vs_d <= s1_vs;
         s1_de   <= in_de;
         s1_de_d <= s1_de;
         s1_data <= in_data;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_ACTIVE, ST_SKIP: begin
            if (vs_rise) state_d = calib_done ? ST_LOAD : ST_SKIP;
         end
         ST_LOAD: begin
            if (ld_cnt_q == LOAD_END) state_d = ST_ACTIVE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pixels are only packed in ACTIVE; vsync wins over a coincident pixel.
   always_comb begin
      enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);
      take_pix   = (state_q == ST_ACTIVE) && s1_de && !vs_rise;
      line_end   = (state_q == ST_ACTIVE) && de_fall;
      flush      = line_end && phase_q;
      line_err   = line_end && (phase_q || (pix_cnt_q != IMG_W_C));
      frame_end  = (state_q == ST_ACTIVE) && vs_rise;
      err_d      = err_q | line_err | ((state_q == ST_LOAD) && s1_de);
      line_d     = line_cnt_q;
      if (line_end && (line_cnt_q != LINE_MAX)) line_d = line_cnt_q + LCW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ld_cnt_q    <= '0;
         pix_cnt_q   <= '0;
         line_cnt_q  <= '0;
         phase_q     <= 1'b0;
         low_q       <= '0;
         err_q       <= 1'b0;
         err_hold_q  <= 1'b0;
         frame_cnt_q <= '0;
         wr_load_q   <= 1'b0;
         wren_q      <= 1'b0;
         din_q       <= '0;
      end else begin
         state_q   <= state_d;
         wr_load_q <= (state_d == ST_LOAD);
         wren_q    <= (take_pix && phase_q) || flush;
         if (flush)                     din_q <= {PAD_PIX, low_q};
         else if (take_pix && phase_q)  din_q <= {s1_data, low_q};
         // The hold captures the frame's verdict before LOAD wipes err_q.
         if (frame_end) err_hold_q <= err_d | (line_d != IMG_H_C);

         if (enter_load) begin
            ld_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            phase_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end else begin
            err_q <= err_d;
            if (state_q == ST_LOAD) ld_cnt_q <= ld_cnt_q + 8'd1;
            if (take_pix) begin
               phase_q <= ~phase_q;
               if (!phase_q) low_q <= s1_data;
               if (pix_cnt_q != PIX_MAX) pix_cnt_q <= pix_cnt_q + PCW'(1);
            end
            if (line_end) begin
               phase_q    <= 1'b0;
               pix_cnt_q  <= '0;
               line_cnt_q <= line_d;
            end
         end
      end
   end

   assign wr_load     = wr_load_q;
   assign wrfifo_wren = wren_q;
   assign wrfifo_din  = din_q;
   assign frame_err   = err_hold_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ddr3_wr_pixel_packer.sv
// Directed bench for ddr3_wr_pixel_packer with a 4x2 image and 8-cycle load.
// Frame vectors come from a table; LOAD-window, coincident-vsync and reset cases are hand sequences.
module tb_ddr3_wr_pixel_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        calib_done = 1'b0;
   logic        in_vsync = 1'b0;
   logic        in_de = 1'b0;
   logic [15:0] in_data = '0;
   logic        wr_load;
   logic        wrfifo_wren;
   logic [31:0] wrfifo_din;
   logic        frame_err;
   logic [15:0] frame_cnt;

   int checks = 0;
   int failures = 0;
   int load_total = 0;
   int load_mark = 0;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];

   typedef struct packed {
      logic             calib;
      logic [1:0]       n_lines;
      logic [2:0]       len0;
      logic [2:0]       len1;
      logic [7:0][15:0] pix;
      logic [3:0][31:0] words;
      logic [2:0]       nwords;
      logic [3:0]       exp_load;
      logic [15:0]      exp_cnt;
      logic             exp_err;
   } frame_vec_t;

   frame_vec_t tbl [5];

   ddr3_wr_pixel_packer #(.IMG_W(4), .IMG_H(2), .LOAD_LEN(8)) dut (
      .clk(clk), .rst(rst), .calib_done(calib_done), .in_vsync(in_vsync),
      .in_de(in_de), .in_data(in_data), .wr_load(wr_load),
      .wrfifo_wren(wrfifo_wren), .wrfifo_din(wrfifo_din),
      .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Monitor samples registered outputs on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (wrfifo_wren) got_q.push_back(wrfifo_din);
         if (wr_load) load_total <= load_total + 1;
      end
   end

   initial begin
      #300000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic start_frame(input logic calib, input logic exp_prev_err, input logic [15:0] exp_cnt);
      load_mark = load_total;
      got_q.delete();
      calib_done = calib;
      in_vsync = 1'b1;
      tick();
      tick();
      chk("prev_frame_err", {31'd0, frame_err}, {31'd0, exp_prev_err});
      chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_cnt});
      in_vsync = 1'b0;
   endtask

   task automatic send_lines(input int n_lines, input int len0, input int len1, input logic [7:0][15:0] pix);
      int k = 0;
      for (int ln = 0; ln < n_lines; ln++) begin
         for (int p = 0; p < ((ln == 0) ? len0 : len1); p++) begin
            in_de = 1'b1;
            in_data = pix[k];
            k++;
            tick();
         end
         in_de = 1'b0;
         repeat (4) tick();
      end
      repeat (4) tick();
   endtask

   task automatic check_words(input int exp_load);
      logic [31:0] e;
      chk("load_cycles", load_total - load_mark, exp_load);
      chk("word_count", got_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) chk("word", got_q.pop_front(), e);
      end
      got_q.delete();
   endtask

   initial begin
      logic prev_err;
      logic [7:0][15:0] seq;

      for (int i = 0; i < 5; i++) tbl[i] = '0;
      // Skipped frame: calibration not done.
      tbl[0].calib = 1'b0; tbl[0].n_lines = 2; tbl[0].len0 = 4; tbl[0].len1 = 4;
      for (int i = 0; i < 8; i++) tbl[0].pix[i] = 16'h0101 + 16'(i);
      tbl[0].nwords = 0; tbl[0].exp_load = 0; tbl[0].exp_cnt = 16'd0; tbl[0].exp_err = 1'b0;
      // Clean frame, pixels 1..8.
      tbl[1].calib = 1'b1; tbl[1].n_lines = 2; tbl[1].len0 = 4; tbl[1].len1 = 4;
      for (int i = 0; i < 8; i++) tbl[1].pix[i] = 16'h0001 + 16'(i);
      tbl[1].words[0] = 32'h0002_0001; tbl[1].words[1] = 32'h0004_0003;
      tbl[1].words[2] = 32'h0006_0005; tbl[1].words[3] = 32'h0008_0007;
      tbl[1].nwords = 4; tbl[1].exp_load = 8; tbl[1].exp_cnt = 16'd1; tbl[1].exp_err = 1'b0;
      // Short odd line with flush, then a full line.
      tbl[2].calib = 1'b1; tbl[2].n_lines = 2; tbl[2].len0 = 3; tbl[2].len1 = 4;
      tbl[2].pix[0] = 16'hAAAA; tbl[2].pix[1] = 16'hBBBB; tbl[2].pix[2] = 16'hCCCC;
      for (int i = 0; i < 4; i++) tbl[2].pix[3+i] = 16'h0011 + 16'(i);
      tbl[2].words[0] = 32'hBBBB_AAAA; tbl[2].words[1] = 32'h0000_CCCC;
      tbl[2].words[2] = 32'h0012_0011; tbl[2].words[3] = 32'h0014_0013;
      tbl[2].nwords = 4; tbl[2].exp_load = 8; tbl[2].exp_cnt = 16'd2; tbl[2].exp_err = 1'b1;
      // Only one line in the frame.
      tbl[3].calib = 1'b1; tbl[3].n_lines = 1; tbl[3].len0 = 4; tbl[3].len1 = 0;
      for (int i = 0; i < 4; i++) tbl[3].pix[i] = 16'h0021 + 16'(i);
      tbl[3].words[0] = 32'h0022_0021; tbl[3].words[1] = 32'h0024_0023;
      tbl[3].nwords = 2; tbl[3].exp_load = 8; tbl[3].exp_cnt = 16'd3; tbl[3].exp_err = 1'b1;
      // Clean frame again: error flag must clear.
      tbl[4].calib = 1'b1; tbl[4].n_lines = 2; tbl[4].len0 = 4; tbl[4].len1 = 4;
      for (int i = 0; i < 8; i++) tbl[4].pix[i] = 16'h0031 + 16'(i);
      tbl[4].words[0] = 32'h0032_0031; tbl[4].words[1] = 32'h0034_0033;
      tbl[4].words[2] = 32'h0036_0035; tbl[4].words[3] = 32'h0038_0037;
      tbl[4].nwords = 4; tbl[4].exp_load = 8; tbl[4].exp_cnt = 16'd4; tbl[4].exp_err = 1'b0;

      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      chk("reset_wr_load", {31'd0, wr_load}, 32'd0);
      chk("reset_wren", {31'd0, wrfifo_wren}, 32'd0);
      chk("reset_din", wrfifo_din, 32'd0);
      chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);

      prev_err = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start_frame(tbl[i].calib, prev_err, tbl[i].exp_cnt);
         repeat (10) tick();
         send_lines(int'(tbl[i].n_lines), int'(tbl[i].len0), int'(tbl[i].len1), tbl[i].pix);
         for (int w = 0; w < int'(tbl[i].nwords); w++) exp_q.push_back(tbl[i].words[w]);
         check_words(int'(tbl[i].exp_load));
         prev_err = tbl[i].exp_err;
      end

      // Pixels during the LOAD window are discarded and flag the frame.
      start_frame(1'b1, prev_err, 16'd5);
      in_de = 1'b1;
      in_data = 16'hDEAD;
      repeat (3) tick();
      in_de = 1'b0;
      repeat (7) tick();
      for (int i = 0; i < 8; i++) seq[i] = 16'h0041 + 16'(i);
      send_lines(2, 4, 4, seq);
      exp_q.push_back(32'h0042_0041); exp_q.push_back(32'h0044_0043);
      exp_q.push_back(32'h0046_0045); exp_q.push_back(32'h0048_0047);
      check_words(8);

      // vsync rising together with a pixel: the pixel is dropped.
      load_mark = load_total;
      got_q.delete();
      in_vsync = 1'b1;
      in_de = 1'b1;
      in_data = 16'hBEEF;
      tick();
      in_de = 1'b0;
      tick();
      chk("coincident_prev_err", {31'd0, frame_err}, 32'd1);
      chk("coincident_frame_cnt", {16'd0, frame_cnt}, 32'd6);
      in_vsync = 1'b0;
      repeat (10) tick();

      // Reset mid-line after a single pixel.
      in_de = 1'b1;
      in_data = 16'h5555;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      chk("midrst_wr_load", {31'd0, wr_load}, 32'd0);
      chk("midrst_wren", {31'd0, wrfifo_wren}, 32'd0);
      chk("midrst_din", wrfifo_din, 32'd0);
      chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check_words(8);
      tick();
      rst = 1'b0;
      in_de = 1'b0;
      repeat (3) tick();

      // After reset the next frame packs from phase 0.
      start_frame(1'b1, 1'b0, 16'd1);
      repeat (10) tick();
      for (int i = 0; i < 8; i++) seq[i] = 16'h0061 + 16'(i);
      send_lines(2, 4, 4, seq);
      exp_q.push_back(32'h0062_0061); exp_q.push_back(32'h0064_0063);
      exp_q.push_back(32'h0066_0065); exp_q.push_back(32'h0068_0067);
      check_words(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
